eightbit_serial_subtractor: RTL and testbench
=============================================

# eightbit_serial_subtractor

Bit-serial 8-bit subtractor computing A − B − bin, LSB first, one bit per clock, with a start/done handshake. It performs the inverse operation of the 8-bit ripple adder, with the same flag semantics: borrow-out mirrors carry-out, and overflow is the XOR of the borrow into bit 7 and the borrow out of bit 7. It serves datapaths that trade latency for area: a single 1-bit full-subtractor cell is reused across 8 cycles.

## Interface
- No parameters; width fixed at 8 bits.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- A  input  8  minuend, captured on accepted start.
- B  input  8  subtrahend, captured on accepted start.
- bin  input  1  borrow-in, captured on accepted start.
- diff  output  8  result A − B − bin (mod 256); held until the next accepted start.
- bout  output  1  borrow out of bit 7 (1 = unsigned A < B + bin).
- overflow  output  1  signed two's-complement overflow.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  single-cycle pulse when diff/bout/overflow become valid.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0. If start=1, latch A, B and bin into shift registers; clear the bit counter to 0; go to RUN.
- RUN: busy=1. Each cycle processes bit i = counter:
  - d = a_i ^ b_i ^ br
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - d shifts into diff from the MSB side; a and b shift right; counter increments.
  - At i=7, record the borrow into bit 7 (br before update) as br7_in.
  - After i=7, go to DONE.
- Output registers: diff updates progressively during RUN. bout and overflow update only on the DONE transition: bout = br_next of bit 7, overflow = br7_in ^ bout.
- DONE: done=1, busy=0 for exactly one cycle. If start=1 in DONE, accept it (back-to-back) and go to RUN; otherwise go to IDLE.
- start in RUN is ignored; no queuing.
- A, B and bin may change freely after acceptance without affecting the result.
- Reset (any state, including mid-RUN): state=IDLE; diff=0x00, bout=0, overflow=0, busy=0, done=0; counter and borrow cleared. The in-flight operation is discarded with no done pulse.

## Timing
- Edge E0 samples start=1 → busy=1 from E0.
- Bits 0..7 are processed at edges E1..E8.
- E8 moves to DONE: done=1 and final diff/bout/overflow are visible in the cycle after E8. Latency is 8 cycles from acceptance.
- busy falls at E8, together with the rise of done.
- Back-to-back throughput: one result per 9 cycles when start is held high.
- diff is valid only while done=1 and thereafter until the next acceptance. During RUN it holds partial, shifting values, and verification must not check it then.
- rst has priority over start on the same edge.

## Test plan
- A=0x50, B=0x30, bin=0 → diff=0x20, bout=0, overflow=0; done exactly 8 cycles after the start edge.
- A=0x00, B=0x01, bin=0 → diff=0xFF, bout=1, overflow=0.
- A=0x80, B=0x01, bin=0 → diff=0x7F, bout=0, overflow=1. A=0x7F, B=0xFF, bin=0 → diff=0x80, bout=1, overflow=1.
- A=0x10, B=0x0F, bin=1 → diff=0x00, bout=0, overflow=0. Change A and B during RUN → result unchanged.
- start held high continuously: done pulses every 9 cycles, and each result matches the operands captured at its own acceptance. A start pulse mid-RUN has no effect.
- rst asserted at RUN bit 4 → next cycle state IDLE, all outputs 0, no done. A fresh start afterwards (A=0x05, B=0x03) → diff=0x02.
- Randomized: 1000 operand triples compared against the reference model (A − B − bin); bout and overflow checked per the definitions above.

Source files
------------

// File: rtl/eightbit_serial_subtractor.sv
// eightbit_serial_subtractor
// Bit-serial 8-bit subtractor computing A - B - bin, LSB first, one bit per
// clock. A single full-subtractor cell is reused across eight RUN cycles.
//
// Ports:
//   clk       system clock, all state updates on rising edge
//   rst       synchronous active-high reset
//   start     request, sampled only when not busy (IDLE or DONE)
//   A, B      minuend / subtrahend, captured on accepted start
//   bin       borrow-in, captured on accepted start
//   diff      A - B - bin (mod 256), valid from done until next acceptance
//   bout      borrow out of bit 7 (1 = unsigned A < B + bin)
//   overflow  signed two's-complement overflow
//   busy      high while a subtraction is in progress
//   done      single-cycle pulse when diff/bout/overflow become valid
module eightbit_serial_subtractor (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       bin,
    output logic [7:0] diff,
    output logic       bout,
    output logic       overflow,
    output logic       busy,
    output logic       done
);

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [CNT_W-1:0]   cnt;
    logic               br;

    // Full-subtractor cell on the current LSBs of the operand shift registers
    logic a_bit;
    logic b_bit;
    logic d_bit;
    logic br_next;

    always_comb begin
        a_bit   = a_sh[0];
        b_bit   = b_sh[0];
        d_bit   = a_bit ^ b_bit ^ br;
        br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    end

    // Control, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            cnt      <= '0;
            br       <= 1'b0;
            diff     <= '0;
            bout     <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        br    <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    diff <= {d_bit, diff[WIDTH-1:1]};
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    br   <= br_next;
                    cnt  <= CNT_W'(cnt + CNT_W'(1));
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        // br here is still the borrow into bit 7
                        bout     <= br_next;
                        overflow <= br ^ br_next;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eightbit_serial_subtractor.sv
module tb_eightbit_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       overflow;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    eightbit_serial_subtractor dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A        (A),
        .B        (B),
        .bin      (bin),
        .diff     (diff),
        .bout     (bout),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation from IDLE; optionally scramble inputs or pulse start mid-RUN
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                          input logic [7:0] ed, input logic eb, input logic ev,
                          input bit scramble, input bit pulse, input string tag);
        A = a; B = b; bin = bi; start = 1'b1;
        tick();
        check({tag, "_busy_e0"}, 8'(busy), 8'd1);
        start = 1'b0;
        if (scramble) begin
            A = ~a; B = ~b; bin = ~bi;
        end
        for (int k = 1; k <= 7; k++) begin
            if (pulse && k == 3) begin
                A = 8'hAA; B = 8'h55; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        check({tag, "_done_e7"}, 8'(done), 8'd0);
        tick();
        check({tag, "_done_e8"}, 8'(done), 8'd1);
        check({tag, "_busy_e8"}, 8'(busy), 8'd0);
        check({tag, "_diff"}, diff, ed);
        check({tag, "_bout"}, 8'(bout), 8'(eb));
        check({tag, "_ovf"}, 8'(overflow), 8'(ev));
        tick();
        check({tag, "_done_off"}, 8'(done), 8'd0);
        check({tag, "_diff_hold"}, diff, ed);
    endtask

    // Reference: 9-bit subtraction, overflow from operand/result signs
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic bi,
                         output logic [7:0] d, output logic bo, output logic ov);
        logic [8:0] t;
        t  = {1'b0, a} - {1'b0, b} - 9'(bi);
        d  = t[7:0];
        bo = t[8];
        ov = (a[7] != b[7]) && (t[7] != a[7]);
    endtask

    initial begin
        logic [7:0] ra, rb, rd;
        logic       rbi, rbo, rov;

        rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; bin = 1'b0;
        tick();
        tick();
        check("rst_diff", diff, 8'h00);
        check("rst_bout", 8'(bout), 8'd0);
        check("rst_ovf", 8'(overflow), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_done", 8'(done), 8'd0);
        rst = 1'b0;
        tick();

        run_op(8'h50, 8'h30, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, "t50_30");
        run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, "t00_01");
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, "t80_01");
        run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, "t7F_FF");
        run_op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "t10_0F_b");
        run_op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "scramble");
        run_op(8'h50, 8'h30, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1, "midpulse");

        // Back-to-back with start held high
        A = 8'h33; B = 8'h11; bin = 1'b0; start = 1'b1;
        tick();
        A = 8'h01; B = 8'h02; bin = 1'b1;
        for (int k = 1; k <= 8; k++) tick();
        check("b2b1_done", 8'(done), 8'd1);
        check("b2b1_diff", diff, 8'h22);
        check("b2b1_bout", 8'(bout), 8'd0);
        tick();
        check("b2b2_busy", 8'(busy), 8'd1);
        check("b2b2_done_low", 8'(done), 8'd0);
        A = 8'h99; B = 8'h99; bin = 1'b0;
        for (int k = 1; k <= 7; k++) tick();
        check("b2b2_done_e7", 8'(done), 8'd0);
        start = 1'b0;
        tick();
        check("b2b2_done", 8'(done), 8'd1);
        check("b2b2_diff", diff, 8'hFE);
        check("b2b2_bout", 8'(bout), 8'd1);
        check("b2b2_ovf", 8'(overflow), 8'd0);
        tick();
        check("b2b_idle_busy", 8'(busy), 8'd0);
        check("b2b_idle_done", 8'(done), 8'd0);

        // Reset during RUN bit 4
        A = 8'hC3; B = 8'h5A; bin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_diff", diff, 8'h00);
        check("mrst_bout", 8'(bout), 8'd0);
        check("mrst_ovf", 8'(overflow), 8'd0);
        check("mrst_busy", 8'(busy), 8'd0);
        check("mrst_done", 8'(done), 8'd0);
        begin
            int seen = 0;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (done || busy) seen++;
            end
            check("mrst_quiet", 8'(seen), 8'd0);
        end
        run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst");

        // rst wins over start on the same edge
        A = 8'h09; B = 8'h01; start = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_prio_busy", 8'(busy), 8'd0);

        // Random operand triples against the reference model
        for (int n = 0; n < 1000; n++) begin
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rbi = 1'($urandom_range(0, 1));
            model(ra, rb, rbi, rd, rbo, rov);
            A = ra; B = rb; bin = rbi; start = 1'b1;
            tick();
            start = 1'b0;
            for (int k = 1; k <= 8; k++) tick();
            checks++;
            assert (done === 1'b1 && diff === rd && bout === rbo && overflow === rov) else begin
                failures++;
                $error("FAIL rand_%0d observed=done%0b/%0h/%0b/%0b expected=1/%0h/%0b/%0b",
                       n, done, diff, bout, overflow, rd, rbo, rov);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
